// File: rtl/sub_bytes_engine.sv
// AES SubBytes/InvSubBytes engine: LANES bytes per cycle, result 16/LANES cycles after accept, held in DONE until out_ready.
// SUB_BYTES_FWD_EN adds the forward ROM and per-block inv_mode; without it the build is inverse-only.
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv_mode,
  input  logic [127:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  localparam int NPASS = (LANES > 0) ? 16 / LANES : 1;
  localparam int IW    = (NPASS > 1) ? $clog2(NPASS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NPASS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[2047 - 8 * int'(b) -: 8];
  endfunction

`ifdef SUB_BYTES_FWD_EN
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[2047 - 8 * int'(b) -: 8];
  endfunction

  logic mode_q, mode_d;
`else
  logic unused_inv_mode;
  assign unused_inv_mode = inv_mode;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q, state_d;
  logic [127:0]   work_q, work_d;
  logic [IW-1:0]  idx_q, idx_d;

  always_comb begin
    int k;
    k       = 0;
    state_d = state_q;
    work_d  = work_q;
    idx_d   = idx_q;
`ifdef SUB_BYTES_FWD_EN
    mode_d  = mode_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = data_in;
          idx_d   = '0;
`ifdef SUB_BYTES_FWD_EN
          mode_d  = inv_mode;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Lane l of pass idx owns byte idx*LANES+l, byte 0 being the MSB byte.
        for (int l = 0; l < LANES; l++) begin
          k = int'(idx_q) * LANES + l;
`ifdef SUB_BYTES_FWD_EN
          work_d[127 - 8*k -: 8] = mode_q ? sbox_inv(work_q[127 - 8*k -: 8])
                                          : sbox_fwd(work_q[127 - 8*k -: 8]);
`else
          work_d[127 - 8*k -: 8] = sbox_inv(work_q[127 - 8*k -: 8]);
`endif
        end
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      idx_q   <= '0;
`ifdef SUB_BYTES_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      idx_q   <= idx_d;
`ifdef SUB_BYTES_FWD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign data_out  = work_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: one instance per legal LANES value, the LANES=4 one carries the main vectors.
module tb_sub_bytes_engine;

  localparam logic [127:0] V_PT  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] V_SB  = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ALL00 = 128'h0;
  localparam logic [127:0] ALL52 = {16{8'h52}};
  localparam logic [127:0] ALL63 = {16{8'h63}};

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic [4:0]   in_valid = '0;
  logic [4:0]   in_ready;
  logic [4:0]   inv_mode = '0;
  logic [4:0]   out_valid;
  logic [4:0]   out_ready = '0;
  logic [127:0] data_in  [5];
  logic [127:0] data_out [5];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_engine #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .inv_mode  (inv_mode[g]),
      .data_in   (data_in[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g])
    );
  end

  typedef struct {
    logic         mode;
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs[5];
  vec_t sweep;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Offer one block, measure cycles from accept to out_valid, check result, then drain it.
  task automatic run_block(input int g, input logic m, input logic [127:0] din,
                           input logic [127:0] exp, input int exp_lat, input string nm);
    int lat;
    check({nm, " in_ready before accept"}, 128'(in_ready[g]), 128'd1);
    @(negedge clk);
    in_valid[g] = 1'b1;
    inv_mode[g] = m;
    data_in[g]  = din;
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    lat = 0;
    while (!out_valid[g] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({nm, " latency"}, 128'(lat), 128'(exp_lat));
    check({nm, " data_out"}, data_out[g], exp);
    @(negedge clk);
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
    check({nm, " ready/valid after drain"}, {126'd0, in_ready[g], out_valid[g]}, 128'b10);
  endtask

  task automatic stream(input int g, input logic m, input logic [127:0] din, input logic [127:0] exp);
    int t0, t1, n, guard;
    n = 0; t0 = 0; t1 = 0; guard = 0;
    @(negedge clk);
    in_valid[g]  = 1'b1;
    out_ready[g] = 1'b1;
    inv_mode[g]  = m;
    data_in[g]   = din;
    while (n < 2 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
      if (out_valid[g]) begin
        if (n == 0) t0 = cyc; else t1 = cyc;
        n++;
      end
    end
    check($sformatf("stream L%0d data", 1 << g), data_out[g], exp);
    check($sformatf("stream L%0d period", 1 << g), 128'(t1 - t0), 128'((16 >> g) + 2));
    @(negedge clk);
    in_valid[g] = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    out_ready[g] = 1'b0;
  endtask

  initial begin
    int seen;
    logic [127:0] held;
    for (int i = 0; i < 5; i++) data_in[i] = '0;

`ifdef SUB_BYTES_FWD_EN
    vecs[0] = '{1'b0, V_PT,  V_SB};
    vecs[1] = '{1'b1, V_SB,  V_PT};
    vecs[2] = '{1'b1, ALL00, ALL52};
    vecs[3] = '{1'b1, ALL63, ALL00};
    vecs[4] = '{1'b0, ALL00, ALL63};
    sweep   = '{1'b0, V_PT,  V_SB};
`else
    vecs[0] = '{1'b1, V_SB,  V_PT};
    vecs[1] = '{1'b1, ALL00, ALL52};
    vecs[2] = '{1'b1, ALL63, ALL00};
    vecs[3] = '{1'b0, ALL00, ALL52};
    vecs[4] = '{1'b0, V_SB,  V_PT};
    sweep   = '{1'b1, V_SB,  V_PT};
`endif

    #1;
    check("reset in_ready", 128'(in_ready), 128'h1f);
    check("reset out_valid", 128'(out_valid), 128'h0);
    check("reset data_out", data_out[2], 128'h0);
    @(negedge clk);
    n_rst = 1'b1;

    for (int i = 0; i < 5; i++)
      run_block(2, vecs[i].mode, vecs[i].din, vecs[i].exp, 4, $sformatf("vec%0d", i));

    // Abort a LANES=1 block mid-way through its 16 passes.
    @(negedge clk);
    in_valid[0] = 1'b1;
    inv_mode[0] = sweep.mode;
    data_in[0]  = sweep.din;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("busy in_ready", 128'(in_ready[0]), 128'd0);
    #2;
    n_rst = 1'b0;
    #1;
    check("async rst in_ready", 128'(in_ready[0]), 128'd1);
    check("async rst out_valid", 128'(out_valid[0]), 128'd0);
    check("async rst data_out", data_out[0], 128'h0);
    @(negedge clk);
    n_rst = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid[0]) seen++;
    end
    check("aborted block out_valid", 128'(seen), 128'd0);

    // Backpressure in DONE with noisy inputs.
    @(negedge clk);
    in_valid[2] = 1'b1;
    inv_mode[2] = vecs[0].mode;
    data_in[2]  = vecs[0].din;
    @(posedge clk);
    #1;
    while (!out_valid[2] && seen < 40) begin
      @(posedge clk);
      #1;
      seen++;
    end
    held = data_out[2];
    check("bp first result", held, vecs[0].exp);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      inv_mode[2] = ~inv_mode[2];
      data_in[2]  = {4{$urandom}};
      @(posedge clk);
      #1;
      check($sformatf("bp hold c%0d", c), {data_out[2], in_ready[2], out_valid[2]}, {held, 2'b01});
    end
    @(negedge clk);
    in_valid[2]  = 1'b0;
    out_ready[2] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[2] = 1'b0;
    check("bp release in_ready", 128'(in_ready[2]), 128'd1);
    repeat (3) @(posedge clk);
    #1;
    check("bp no new block", {data_out[2], out_valid[2]}, {held, 1'b0});

    for (int g = 0; g < 5; g++)
      run_block(g, sweep.mode, sweep.din, sweep.exp, 16 >> g, $sformatf("sweep L%0d", 1 << g));

    for (int g = 0; g < 5; g++)
      stream(g, sweep.mode, sweep.din, sweep.exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
